// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, in-order imem requests, and a
// small PC/instruction buffer that feeds the fetch/decode register one word per cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_en,
  input  logic [31:0] jmp_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] curr_pc,
  output logic [31:0] ACIns
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] drop_cnt;
  logic [PW-1:0] occupancy;
  logic [31:0]   pc_buf    [DEPTH];
  logic [31:0]   instr_buf [DEPTH];

  logic grant;
  logic fill_en;
  logic drop_en;
  logic consume;

  // Slots are reserved at grant time, so occupancy counts in-flight requests too.
  assign occupancy = alloc_ptr - rd_ptr;
  assign imem_req  = !rst && (occupancy < PW'(DEPTH)) && (drop_cnt == '0) && !jmp_en;
  assign imem_addr = fetch_pc;

  assign grant   = imem_req && imem_gnt;
  assign fill_en = imem_rvalid && (drop_cnt == '0) && !jmp_en;
  assign drop_en = imem_rvalid && (drop_cnt != '0);
  assign consume = ins_valid && !stall;

  assign ins_valid = (fill_ptr != rd_ptr) && !jmp_en;
  assign curr_pc   = ins_valid ? pc_buf[rd_ptr[AW-1:0]]    : 32'h0;
  assign ACIns     = ins_valid ? instr_buf[rd_ptr[AW-1:0]] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
    end else if (jmp_en) begin
      fetch_pc  <= jmp_target & ~32'h3;
      // Every unfilled request becomes a stale response; one arriving now is already gone.
      drop_cnt  <= drop_cnt + (alloc_ptr - fill_ptr) - {{AW{1'b0}}, imem_rvalid};
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
    end else begin
      if (grant) begin
        alloc_ptr <= alloc_ptr + 1'b1;
        fetch_pc  <= fetch_pc + 32'd4;
      end
      if (fill_en) fill_ptr <= fill_ptr + 1'b1;
      if (drop_en) drop_cnt <= drop_cnt - 1'b1;
      if (consume) rd_ptr   <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant)   pc_buf[alloc_ptr[AW-1:0]]   <= fetch_pc;
    if (fill_en) instr_buf[fill_ptr[AW-1:0]] <= imem_rdata;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for straight-line/stall/jump
// behaviour plus hand sequences for drops, wrap-around and mid-stream reset.
module tb_instr_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jmp_en;
  logic [31:0] jmp_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] curr_pc;
  logic [31:0] ACIns;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_ins;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst), .jmp_en(jmp_en), .jmp_target(jmp_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ins_valid(ins_valid), .curr_pc(curr_pc), .ACIns(ACIns)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst), .jmp_en(1'b0), .jmp_target(32'h0), .stall(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .ins_valid(w_valid), .curr_pc(w_pc), .ACIns(w_ins)
  );

  // Memory model: fixed-latency in-order responses, rdata = addr ^ PAT.
  int          mem_lat = 1;
  int          grant_cnt = 0;
  int          q_age[$];
  logic [31:0] q_addr[$];
  logic        gr_s = 1'b0;
  logic        rv_s = 1'b0;
  logic [31:0] ad_s = 32'h0;
  logic        w_nxt_rv = 1'b0;
  logic [31:0] w_nxt_rd = 32'h0;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    w_rvalid    = 1'b0;
    w_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && q_addr.size() > 0 && q_age[0] >= mem_lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = q_addr[0] ^ PAT;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      w_rvalid = rst ? 1'b0 : w_nxt_rv;
      w_rdata  = w_nxt_rd;
      #2;
      gr_s     = imem_req & imem_gnt;
      ad_s     = imem_addr;
      rv_s     = imem_rvalid;
      w_nxt_rv = !rst && w_req;
      w_nxt_rd = w_addr ^ PAT;
    end
  end

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q_age.delete();
        q_addr.delete();
        grant_cnt = 0;
      end else begin
        if (rv_s && q_addr.size() > 0) begin
          void'(q_age.pop_front());
          void'(q_addr.pop_front());
        end
        foreach (q_age[i]) q_age[i] = q_age[i] + 1;
        if (gr_s) begin
          q_age.push_back(1);
          q_addr.push_back(ad_s);
          grant_cnt = grant_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    jmp_en = 1'b0;
    jmp_target = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Jump at cycle jc; requests must resume at 'resume' from the aligned target,
  // and the first presented instruction (cycle 'first') must come from the target.
  task automatic run_jump(input int lat, input int jc, input logic [31:0] tgt,
                          input int resume, input int first);
    logic [31:0] atgt;
    atgt = tgt & ~32'h3;
    mem_lat = lat;
    do_reset();
    for (int c = 0; c <= first; c++) begin
      @(negedge clk);
      jmp_en = (c == jc);
      jmp_target = tgt;
      #1;
      if (c == jc) begin
        chk($sformatf("jmp%0d_c%0d_req", lat, c), imem_req, 1'b0);
        chk($sformatf("jmp%0d_c%0d_vld", lat, c), ins_valid, 1'b0);
      end
      if (c > jc) begin
        chk($sformatf("jmp%0d_c%0d_vld", lat, c), ins_valid, (c == first));
        if (c < first)
          chk($sformatf("jmp%0d_c%0d_req", lat, c), imem_req, (c >= resume));
        if (c == resume)
          chk($sformatf("jmp%0d_c%0d_addr", lat, c), imem_addr, atgt);
        if (c == first) begin
          chk($sformatf("jmp%0d_c%0d_pc", lat, c), curr_pc, atgt);
          chk($sformatf("jmp%0d_c%0d_ins", lat, c), ACIns, atgt ^ PAT);
        end
      end
    end
    jmp_en = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        jmp;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  initial begin
    //         stall jmp  tgt          req  addr          vld  pc
    vec[0]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h00, 1'b0, 32'h00};
    vec[1]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h04, 1'b0, 32'h00};
    vec[2]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h08, 1'b1, 32'h00};
    vec[3]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h0C, 1'b1, 32'h04};
    vec[4]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h10, 1'b1, 32'h08};
    vec[5]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h14, 1'b1, 32'h0C};
    vec[6]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h18, 1'b1, 32'h0C};
    vec[7]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h1C, 1'b1, 32'h0C};
    vec[8]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h1C, 1'b1, 32'h0C};
    vec[9]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h1C, 1'b1, 32'h10};
    vec[10] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h20, 1'b1, 32'h14};
    vec[11] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h24, 1'b1, 32'h18};
    vec[12] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h28, 1'b1, 32'h1C};
    vec[13] = '{1'b0, 1'b1, 32'h100,   1'b0, 32'h2C, 1'b0, 32'h00};
    vec[14] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h100, 1'b0, 32'h00};
    vec[15] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h104, 1'b0, 32'h00};
    vec[16] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h108, 1'b1, 32'h100};

    rst = 1'b1;
    stall = 1'b0;
    jmp_en = 1'b0;
    jmp_target = 32'h0;
    imem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_vld", ins_valid, 1'b0);
    chk("rst_pc", curr_pc, 32'h0);
    chk("rst_ins", ACIns, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    chk("rst_wrap_req", w_req, 1'b0);

    // Straight-line fetch, stall/backpressure, and a jump with a coincident response.
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      stall = vec[k].stall;
      jmp_en = vec[k].jmp;
      jmp_target = vec[k].tgt;
      #1;
      chk($sformatf("tbl%0d_req", k), imem_req, vec[k].req);
      chk($sformatf("tbl%0d_addr", k), imem_addr, vec[k].addr);
      chk($sformatf("tbl%0d_vld", k), ins_valid, vec[k].vld);
      chk($sformatf("tbl%0d_pc", k), curr_pc, vec[k].pc);
      chk($sformatf("tbl%0d_ins", k), ACIns, vec[k].vld ? (vec[k].pc ^ PAT) : 32'h0);
    end
    jmp_en = 1'b0;

    // Stall from reset: buffer fills with exactly DEPTH grants, then drains in order.
    mem_lat = 1;
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
    end
    chk("fill_grants", grant_cnt, 4);
    chk("fill_req_off", imem_req, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      stall = 1'b0;
      #1;
      chk($sformatf("drain%0d_vld", c), ins_valid, 1'b1);
      chk($sformatf("drain%0d_pc", c), curr_pc, 32'(4 * c));
      if (c == 0) chk("drain_req_still_off", imem_req, 1'b0);
      if (c == 1) chk("drain_req_back", imem_req, 1'b1);
    end

    run_jump(3, 3, 32'h100, 6, 10);
    run_jump(2, 2, 32'h203, 4, 7);

    // PC wrap-around on the instance reset to FFFF_FFF8.
    mem_lat = 1;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) chk("wrap_c0_addr", w_addr, 32'hFFFF_FFF8);
      if (c == 2) chk("wrap_c2_pc", w_pc, 32'hFFFF_FFF8);
      if (c == 3) chk("wrap_c3_pc", w_pc, 32'hFFFF_FFFC);
      if (c == 4) chk("wrap_c4_pc", w_pc, 32'h0000_0000);
      if (c == 4) chk("wrap_c4_ins", w_ins, PAT);
      if (c >= 2) chk($sformatf("wrap_c%0d_vld", c), w_valid, 1'b1);
    end

    // Reset asserted mid-cycle with two buffered instructions.
    mem_lat = 1;
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_pre_vld", ins_valid, 1'b1);
    chk("mid_pre_pc", curr_pc, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", ins_valid, 1'b0);
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_pc", curr_pc, 32'h0);
    chk("mid_rst_ins", ACIns, 32'h0);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) chk("mid_after_req", imem_req, 1'b1);
      if (c == 0) chk("mid_after_addr", imem_addr, 32'h0);
      if (c == 2) chk("mid_after_vld", ins_valid, 1'b1);
      if (c == 2) chk("mid_after_pc", curr_pc, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch unit that generates the program counter and issues in-order read requests to instruction memory. It buffers the returned 32-bit instruction words with their PCs and presents them, one per cycle, to the fetch/decode pipeline register as `curr_pc` / `ACIns`. Taken jumps redirect the PC, flush all buffered instructions, and discard responses still in flight. The block sits between the instruction memory port and the fetch pipeline register.

## Interface
- RESET_PC, 32'h0, PC loaded on reset
- DEPTH, 4, instruction buffer entries; power of two, ≥2; also the maximum number of requests in flight

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- jmp_en  in  1  redirect request (taken jump/branch)
- jmp_target  in  32  new PC when jmp_en=1
- stall  in  1  downstream holds; the head instruction is not consumed
- imem_req  out  1  read request
- imem_addr  out  32  request address (byte address, word aligned)
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid; responses arrive in request order, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- ins_valid  out  1  curr_pc/ACIns hold a valid instruction
- curr_pc  out  32  PC of the presented instruction
- ACIns  out  32  presented instruction word

## Operation
- State:
  - fetch_pc (32).
  - Circular buffer of DEPTH entries {pc, instr}, with three pointers of log2(DEPTH)+1 bits: alloc_ptr, fill_ptr, rd_ptr.
  - drop_cnt, log2(DEPTH)+1 bits.
- Allocation:
  - `imem_req = (alloc_ptr - rd_ptr) < DEPTH && drop_cnt == 0 && !jmp_en`.
  - `imem_addr = fetch_pc`.
- Grant (imem_req & imem_gnt):
  - Write fetch_pc into entry[alloc_ptr].pc.
  - alloc_ptr++.
  - fetch_pc += 4, wrapping modulo 2^32.
- Response (imem_rvalid):
  - If drop_cnt != 0: drop_cnt--, data discarded.
  - Otherwise: write imem_rdata into entry[fill_ptr].instr and fill_ptr++.
- Output:
  - `ins_valid = (fill_ptr != rd_ptr) && !jmp_en`.
  - curr_pc/ACIns = entry[rd_ptr] when ins_valid, else 0.
  - Consume when ins_valid & !stall: rd_ptr++.
- Jump (jmp_en=1), applied at the clock edge:
  - fetch_pc ← jmp_target.
  - drop_cnt ← drop_cnt + (alloc_ptr − fill_ptr) − (this cycle's rvalid counted as a drop).
  - alloc_ptr, fill_ptr, rd_ptr ← 0.
  - No request, fill or consume takes effect in a jump cycle.
  - jmp_target[1:0] is ignored; it is forced to 00.
- imem_rvalid with no outstanding or droppable request is a protocol error; the block's behaviour is then unspecified.

## Timing
- Reset values:
  - fetch_pc=RESET_PC; all pointers and drop_cnt = 0.
  - Outputs: ins_valid=0, curr_pc=0, ACIns=0, imem_req=0 while rst is high, imem_addr=RESET_PC.
- First request: imem_req=1 in the first cycle after rst deasserts.
- Latency:
  - rvalid in cycle N → ins_valid=1 with that instruction in cycle N+1.
  - Zero-wait memory (gnt in cycle N, rvalid in cycle N+1) → first instruction visible in cycle N+2.
- Throughput: one instruction per cycle sustained when gnt=1, rvalid follows every grant, and stall=0.
- Full buffer (alloc_ptr − rd_ptr == DEPTH): imem_req=0 until a consume frees an entry; the request reasserts the cycle after the consume.
- Empty buffer: ins_valid=0; stall has no effect.
- Simultaneous events:
  - Grant, fill and consume in the same cycle are all applied.
  - jmp_en overrides stall, gnt, rvalid filling, and consume.
- After a jump:
  - Requests from jmp_target start once drop_cnt reaches 0, earliest the cycle after jmp_en.
  - Back-to-back jumps accumulate drop_cnt correctly.
- Reset mid-operation: all state returns to reset values immediately. In-flight memory responses are the memory's responsibility to cancel.

## Test plan
- **Reset and straight-line fetch.** Reset, zero-wait memory returning rdata = addr ^ 32'hA5A5_0000, stall=0 → ins_valid from cycle 2 after reset; curr_pc sequence 0,4,8,…; ACIns matches the pattern; one instruction per cycle.
- **Stall and fill.** DEPTH=4, stall=1 for 10 cycles → exactly 4 grants, then imem_req=0. Release stall → PCs 0,4,8,12 presented in order, followed by 16.
- **Jump with drops.** Memory latency 3, jump to 32'h100 while 3 requests are in flight → the 3 stale responses are discarded; the next presented curr_pc is 0x100; no stale PC ever reaches the output.
- **Jump with a coincident response.** jmp_en in the same cycle as rvalid, with 1 other request outstanding → drop_cnt=1; that one response is dropped; the first instruction after the jump is from jmp_target.
- **Wrap-around.** RESET_PC=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Mid-operation reset.** Assert rst mid-stream with the buffer half full → ins_valid drops in the same cycle; after release, fetch restarts at RESET_PC.
